// File: rtl/k_and_s_pkg.sv
// Shared types and sizing constants for the K&S processor memory side.
package k_and_s_pkg;

    localparam int KS_DATA_WIDTH = 16;
    localparam int KS_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        MEM_CLEAR,
        MEM_LOAD,
        MEM_RUN
    } mem_state_type;

endpackage

// File: rtl/ks_ram_32x16.sv
// Single-write-port word store with a registered read port; a read and write to the
// same address in one cycle returns the word as it was before the write.
module ks_ram_32x16 #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] read_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (write_enable) begin
            mem[write_addr] <= write_data;
        end
        read_data <= mem[read_addr];
    end

endmodule

// File: rtl/ks_memory_responder.sv
// Memory-side responder: clears and boot-loads the word store, then serves CPU
// reads/writes with a memory-mapped output register, holding the CPU in reset until then.
module ks_memory_responder
    import k_and_s_pkg::*;
#(
    parameter int DATA_WIDTH     = KS_DATA_WIDTH,
    parameter int ADDR_WIDTH     = KS_ADDR_WIDTH,
    parameter bit CLEAR_ON_RESET = 1'b1,
    parameter int IO_ADDR        = 31
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic                  ram_write_enable,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic [DATA_WIDTH-1:0] data_in,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  cpu_rst_n,
    output logic [DATA_WIDTH-1:0] io_out,
    output logic                  busy
);

    localparam mem_state_type         RESET_STATE = CLEAR_ON_RESET ? MEM_CLEAR : MEM_LOAD;
    localparam logic [ADDR_WIDTH-1:0] IO_ADDR_W   = ADDR_WIDTH'(IO_ADDR);

    mem_state_type         state_reg, state_next;
    logic [ADDR_WIDTH:0]   ptr_reg, ptr_next, ptr_inc;
    logic                  read_valid_reg;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  io_we;

    // The extra pointer bit flags the wrap past the last word.
    assign ptr_inc = ptr_reg + (ADDR_WIDTH + 1)'(1);

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        ram_we     = 1'b0;
        ram_waddr  = ptr_reg[ADDR_WIDTH-1:0];
        ram_wdata  = '0;
        io_we      = 1'b0;
        case (state_reg)
            MEM_CLEAR: begin
                ram_we   = 1'b1;
                ptr_next = ptr_inc;
                if (ptr_inc[ADDR_WIDTH]) begin
                    ptr_next   = '0;
                    state_next = MEM_LOAD;
                end
            end
            MEM_LOAD: begin
                ram_wdata = load_data;
                if (load_valid && load_ready) begin
                    ram_we   = 1'b1;
                    ptr_next = ptr_inc;
                    if (load_last || ptr_inc[ADDR_WIDTH]) begin
                        state_next = MEM_RUN;
                    end
                end
            end
            MEM_RUN: begin
                ram_we    = ram_write_enable;
                ram_waddr = ram_addr;
                ram_wdata = data_out;
                io_we     = ram_write_enable && (ram_addr == IO_ADDR_W);
            end
            default: begin
                state_next = RESET_STATE;
                ptr_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= RESET_STATE;
            ptr_reg        <= '0;
            load_ready     <= 1'b0;
            cpu_rst_n      <= 1'b0;
            io_out         <= '0;
            read_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            load_ready     <= (state_next == MEM_LOAD);
            cpu_rst_n      <= (state_reg == MEM_RUN);
            read_valid_reg <= (state_reg == MEM_RUN);
            if (io_we) begin
                io_out <= data_out;
            end
        end
    end

    assign busy    = (state_reg != MEM_RUN);
    // The RAM output register has no reset, so read data is masked until a RUN read lands.
    assign data_in = read_valid_reg ? ram_rdata : '0;

    ks_ram_32x16 #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk         (clk),
        .write_enable(ram_we),
        .write_addr  (ram_waddr),
        .write_data  (ram_wdata),
        .read_addr   (ram_addr),
        .read_data   (ram_rdata)
    );

endmodule

// File: tb/tb_ks_memory_responder.sv
// Directed bench for ks_memory_responder: clear, boot load, CPU access, IO register, resets.
module tb_ks_memory_responder;

    logic        clk;
    logic        rst_n;
    logic [4:0]  ram_addr;
    logic        ram_write_enable;
    logic [15:0] data_out;
    logic [15:0] data_in;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic        load_last;
    logic        cpu_rst_n;
    logic [15:0] io_out;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    ks_memory_responder dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ram_addr        (ram_addr),
        .ram_write_enable(ram_write_enable),
        .data_out        (data_out),
        .data_in         (data_in),
        .load_valid      (load_valid),
        .load_ready      (load_ready),
        .load_data       (load_data),
        .load_last       (load_last),
        .cpu_rst_n       (cpu_rst_n),
        .io_out          (io_out),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, observed, expected);
        end else begin
            $display("ok   %s: 0x%04h", tag, observed);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [15:0] data, input logic last);
        load_valid = 1'b1;
        load_data  = data;
        load_last  = last;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic cpu_write(input logic [4:0] addr, input logic [15:0] data);
        ram_addr         = addr;
        data_out         = data;
        ram_write_enable = 1'b1;
        step();
        ram_write_enable = 1'b0;
    endtask

    task automatic cpu_read(input string tag, input logic [4:0] addr, input logic [15:0] expected);
        ram_addr = addr;
        step();
        check_value(tag, data_in, expected);
    endtask

    // Mid-cycle async reset: outputs must drop without waiting for a clock edge.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_value({tag, " cpu_rst_n"}, {15'd0, cpu_rst_n}, 16'd0);
        check_value({tag, " data_in"}, data_in, 16'h0000);
        check_value({tag, " io_out"}, io_out, 16'h0000);
        check_value({tag, " busy"}, {15'd0, busy}, 16'd1);
        check_value({tag, " load_ready"}, {15'd0, load_ready}, 16'd0);
        step();
        rst_n = 1'b1;
    endtask

    // CLEAR takes exactly 32 edges after release; load_ready appears on the 32nd.
    task automatic wait_clear(input string tag);
        repeat (31) step();
        check_value({tag, " busy in clear"}, {15'd0, busy}, 16'd1);
        check_value({tag, " ready in clear"}, {15'd0, load_ready}, 16'd0);
        step();
        check_value({tag, " ready after clear"}, {15'd0, load_ready}, 16'd1);
    endtask

    logic [15:0] prog [3];

    initial begin
        rst_n            = 1'b0;
        ram_addr         = '0;
        ram_write_enable = 1'b0;
        data_out         = '0;
        load_valid       = 1'b0;
        load_data        = '0;
        load_last        = 1'b0;
        prog[0] = 16'h8105;
        prog[1] = 16'hA104;
        prog[2] = 16'hFF00;

        #12;
        check_value("rst data_in", data_in, 16'h0000);
        check_value("rst load_ready", {15'd0, load_ready}, 16'd0);
        check_value("rst cpu_rst_n", {15'd0, cpu_rst_n}, 16'd0);
        check_value("rst io_out", io_out, 16'h0000);
        check_value("rst busy", {15'd0, busy}, 16'd1);
        step();
        rst_n = 1'b1;
        wait_clear("t1");

        for (int i = 0; i < 3; i++) begin
            load_word(prog[i], i == 2);
        end
        check_value("t2 busy in run", {15'd0, busy}, 16'd0);
        check_value("t2 ready in run", {15'd0, load_ready}, 16'd0);
        check_value("t2 cpu_rst_n entry", {15'd0, cpu_rst_n}, 16'd0);
        ram_addr = 5'd0;
        step();
        check_value("t2 cpu_rst_n rise", {15'd0, cpu_rst_n}, 16'd1);
        check_value("t2 read 0", data_in, prog[0]);
        for (int i = 1; i < 32; i++) begin
            cpu_read($sformatf("t2 read %0d", i), 5'(i), (i < 3) ? prog[i] : 16'h0000);
        end

        cpu_write(5'd7, 16'h1234);
        cpu_read("t4 read 7", 5'd7, 16'h1234);
        cpu_write(5'd9, 16'h5555);
        check_value("t4 rbw old 9", data_in, 16'h0000);
        cpu_read("t4 read 9 new", 5'd9, 16'h5555);

        cpu_write(5'd31, 16'hBEEF);
        check_value("t5 io_out set", io_out, 16'hBEEF);
        cpu_read("t5 read 31", 5'd31, 16'hBEEF);
        cpu_write(5'd30, 16'h0101);
        check_value("t5 io_out held", io_out, 16'hBEEF);
        cpu_read("t5 read 30", 5'd30, 16'h0101);

        async_reset("run rst");
        wait_clear("t6a");
        for (int i = 0; i < 5; i++) begin
            load_word(16'hAA00 + 16'(i), 1'b0);
        end
        check_value("t6 busy mid load", {15'd0, busy}, 16'd1);
        async_reset("load rst");
        wait_clear("t6b");
        load_word(16'h0077, 1'b1);
        cpu_read("t6 read 0", 5'd0, 16'h0077);
        for (int i = 1; i < 6; i++) begin
            cpu_read($sformatf("t6 read %0d", i), 5'(i), 16'h0000);
        end

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        wait_clear("t3");
        for (int i = 0; i < 31; i++) begin
            load_word(16'h1000 + 16'(i), 1'b0);
        end
        check_value("t3 ready before 32nd", {15'd0, load_ready}, 16'd1);
        load_word(16'h101F, 1'b0);
        check_value("t3 ready after 32nd", {15'd0, load_ready}, 16'd0);
        check_value("t3 busy after 32nd", {15'd0, busy}, 16'd0);
        load_word(16'hDEAD, 1'b1);
        check_value("t3 ready 33rd", {15'd0, load_ready}, 16'd0);
        cpu_read("t3 read 0", 5'd0, 16'h1000);
        cpu_read("t3 read 15", 5'd15, 16'h100F);
        cpu_read("t3 read 31", 5'd31, 16'h101F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
